// File: rtl/sha256_round_engine.sv
//-----------------------------------------------------------------------------
// sha256_round_engine
//
// SHA-256 compression of one 512-bit chunk against a supplied 256-bit
// chaining state, evaluating UNROLL rounds per clock. Valid/ready handshakes
// on both the chunk input and the hash output.
//
// Parameters:
//   UNROLL  rounds per clock; 1, 2, 4 or 8 (anything else fails elaboration)
//   ROUNDS  compression rounds, 64 in real use; a multiple of UNROLL
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   chunk and V_in present
//   in_ready   engine can accept a chunk (IDLE, or DONE while out_ready)
//   data       512-bit chunk; word i = flipbytes(data[32i+31:32i])
//   V_in       chaining state; a..h = V_in[31:0]..V_in[255:224], unflipped
//   out_valid  hash holds a result
//   out_ready  consumer takes the result
//   hash       hash[32i+31:32i] = flipbytes(V_i + R_i)
//   busy       high while rounds are running or the result is being formed
//
// Optional feature, macro SHA256_ROUND_ENGINE_TAG_EN:
//   in_tag   32-bit tag captured on the accept edge
//   out_tag  that tag, presented alongside hash/out_valid (resets to 0)
//-----------------------------------------------------------------------------
module sha256_round_engine #(
    parameter int UNROLL = 1,
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] data,
    input  logic [255:0] V_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] hash,
    output logic         busy
`ifdef SHA256_ROUND_ENGINE_TAG_EN
    ,
    input  logic [31:0]  in_tag,
    output logic [31:0]  out_tag
`endif
);

    // Parameter legality is checked at elaboration.
    generate
        if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
            $error("sha256_round_engine: UNROLL must be 1, 2, 4 or 8 (got %0d)", UNROLL);
        end
        if (ROUNDS < UNROLL || ROUNDS > 64 || (ROUNDS % UNROLL) != 0) begin : g_bad_rounds
            $error("sha256_round_engine: ROUNDS must be <= 64 and a multiple of UNROLL (got %0d)", ROUNDS);
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN,
        S_DONE
    } state_t;

    // Counter value at the start of the final RUN edge.
    localparam logic [5:0] LAST_CNT = 6'(ROUNDS - UNROLL);

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    //-------------------------------------------------------------------------
    // SHA-256 primitive functions
    //-------------------------------------------------------------------------
    function automatic logic [31:0] flip32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    //-------------------------------------------------------------------------
    // State
    //-------------------------------------------------------------------------
    state_t             st_reg;
    logic [5:0]         cnt_reg;
    logic [7:0][31:0]   v_reg;      // chaining state latched at accept
    logic [7:0][31:0]   r_reg;      // working variables, index 0 = a
    logic [15:0][31:0]  w_reg;      // sliding schedule window, w_reg[0] = current word
    logic [255:0]       hash_reg;
    logic               out_valid_reg;
`ifdef SHA256_ROUND_ENGINE_TAG_EN
    logic [31:0]        tag_reg;
    logic [31:0]        out_tag_reg;
`endif

    logic               accept;
    logic [15:0][31:0]  w_load;
    logic [7:0][31:0]   hash_next;

    // in_ready is held low for the whole reset pulse, even though the state
    // register already reads IDLE.
    assign in_ready  = ~rst & ((st_reg == S_IDLE) | ((st_reg == S_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign busy      = (st_reg == S_RUN) | (st_reg == S_FIN);
    assign out_valid = out_valid_reg;
    assign hash      = hash_reg;
`ifdef SHA256_ROUND_ENGINE_TAG_EN
    assign out_tag   = out_tag_reg;
`endif

    // Chunk words arrive little-endian per 32-bit lane.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_wload
            assign w_load[gi] = flip32(data[32*gi +: 32]);
        end
    endgenerate

    //-------------------------------------------------------------------------
    // UNROLL chained rounds. Stage gi consumes r_chain[gi]/w_chain[gi] and
    // produces the state and schedule window after one more round.
    //-------------------------------------------------------------------------
    logic [7:0][31:0]  r_chain [UNROLL+1];
    logic [15:0][31:0] w_chain [UNROLL+1];

    assign r_chain[0] = r_reg;
    assign w_chain[0] = w_reg;

    generate
        for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
            logic [31:0] a, b, c, d, e, f, g, h;
            logic [31:0] t1, t2, nw;
            logic [5:0]  ridx;

            assign {h, g, f, e, d, c, b, a} = r_chain[gi];
            // 6-bit round index: the K lookup can never run past entry 63.
            assign ridx = cnt_reg + 6'(gi);
            assign t1   = h + big_sigma1(e) + ch(e, f, g) + K[ridx] + w_chain[gi][0];
            assign t2   = big_sigma0(a) + maj(a, b, c);
            assign r_chain[gi+1] = {g, f, e, d + t1, c, b, a, t1 + t2};

            // Next schedule word, W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16],
            // expressed against the 16-word window; the window shifts once per round.
            assign nw = w_chain[gi][0] + small_sigma0(w_chain[gi][1])
                      + w_chain[gi][9] + small_sigma1(w_chain[gi][14]);
            assign w_chain[gi+1] = {nw, w_chain[gi][15:1]};
        end
    endgenerate

    // Feed-forward add and output byte flip.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_hash
            assign hash_next[gi] = flip32(v_reg[gi] + r_reg[gi]);
        end
    endgenerate

    //-------------------------------------------------------------------------
    // Control FSM and datapath registers
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_reg        <= S_IDLE;
            cnt_reg       <= '0;
            v_reg         <= '0;
            r_reg         <= '0;
            w_reg         <= '0;
            hash_reg      <= '0;
            out_valid_reg <= 1'b0;
`ifdef SHA256_ROUND_ENGINE_TAG_EN
            tag_reg       <= '0;
            out_tag_reg   <= '0;
`endif
        end else begin
            case (st_reg)
                S_IDLE: begin
                    // Leaves only through an accept, handled below.
                end
                S_RUN: begin
                    r_reg   <= r_chain[UNROLL];
                    w_reg   <= w_chain[UNROLL];
                    cnt_reg <= cnt_reg + 6'(UNROLL);
                    if (cnt_reg == LAST_CNT) begin
                        st_reg <= S_FIN;
                    end
                end
                S_FIN: begin
                    hash_reg      <= hash_next;
                    out_valid_reg <= 1'b1;
`ifdef SHA256_ROUND_ENGINE_TAG_EN
                    out_tag_reg   <= tag_reg;
`endif
                    st_reg        <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        st_reg        <= S_IDLE;
                    end
                end
                default: begin
                    st_reg <= S_IDLE;
                end
            endcase

            // Accept is only possible from IDLE or from DONE on the output
            // handshake edge; it overrides the IDLE transition above so a new
            // chunk starts with no idle cycle. hash/out_tag are left alone.
            if (accept) begin
                v_reg   <= V_in;
                r_reg   <= V_in;
                w_reg   <= w_load;
                cnt_reg <= '0;
`ifdef SHA256_ROUND_ENGINE_TAG_EN
                tag_reg <= in_tag;
`endif
                st_reg  <= S_RUN;
            end
        end
    end

endmodule

// File: tb/tb_sha256_round_engine.sv
module tb_sha256_round_engine;

    localparam int NI = 4;      // instances with UNROLL = 1, 2, 4, 8

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [511:0]   data;
    logic [255:0]   v_in;
    logic           out_ready;
    logic [NI-1:0]  in_ready;
    logic [NI-1:0]  out_valid;
    logic [NI-1:0]  busy;
    logic [255:0]   hash [NI];
`ifdef SHA256_ROUND_ENGINE_TAG_EN
    logic [31:0]    in_tag;
    logic [31:0]    out_tag [NI];
`endif

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            sha256_round_engine #(
                .UNROLL (1 << gi),
                .ROUNDS (64)
            ) dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready[gi]),
                .data      (data),
                .V_in      (v_in),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready),
                .hash      (hash[gi]),
                .busy      (busy[gi])
`ifdef SHA256_ROUND_ENGINE_TAG_EN
                ,
                .in_tag    (in_tag),
                .out_tag   (out_tag[gi])
`endif
            );
        end
    endgenerate

    // Watchdog: the run is a few thousand cycles; anything far beyond is a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] flip32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Big-endian block (W0 in the top bits) -> engine data port layout.
    function automatic logic [511:0] pack_block(input logic [511:0] blk);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = flip32(blk[511-32*i -: 32]);
        return d;
    endfunction

    // Big-endian digest (H0 in the top bits) -> expected hash port value.
    function automatic logic [255:0] pack_digest(input logic [255:0] dg);
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[32*i +: 32] = flip32(dg[255-32*i -: 32]);
        return h;
    endfunction

    // Hash port value -> chaining state for the next block.
    function automatic logic [255:0] hash_to_v(input logic [255:0] h);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = flip32(h[32*i +: 32]);
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents one chunk (acknowledging any held result on the same edge),
    // then checks per-instance latency, digest and tag.
    task automatic run_chunk(input string name, input logic [511:0] d, input logic [255:0] v,
                             input logic [31:0] tag, input logic [255:0] exp, input bit chk_hash);
        int first [NI];
        data      = d;
        v_in      = v;
`ifdef SHA256_ROUND_ENGINE_TAG_EN
        in_tag    = tag;
`endif
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < NI; k++)
            chk($sformatf("%s U%0d in_ready before accept", name, 1 << k), 256'(in_ready[k]), 256'(1));
        @(posedge clk);     // accept edge = edge 0
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data      = {16{32'hffff_0000}};
        v_in      = {8{32'h1234_5678}};
`ifdef SHA256_ROUND_ENGINE_TAG_EN
        in_tag    = 32'h5555_aaaa;
`endif
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s U%0d out_valid after accept", name, 1 << k), 256'(out_valid[k]), 256'(0));
            chk($sformatf("%s U%0d busy after accept", name, 1 << k), 256'(busy[k]), 256'(1));
            first[k] = 0;
        end
        for (int e = 1; e <= 70; e++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NI; k++)
                if (out_valid[k] && first[k] == 0) first[k] = e;
        end
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s U%0d latency", name, 1 << k), 256'(first[k]), 256'(64 / (1 << k) + 1));
            chk($sformatf("%s U%0d out_valid held", name, 1 << k), 256'(out_valid[k]), 256'(1));
            chk($sformatf("%s U%0d busy in done", name, 1 << k), 256'(busy[k]), 256'(0));
            if (chk_hash)
                chk($sformatf("%s U%0d hash", name, 1 << k), hash[k], exp);
`ifdef SHA256_ROUND_ENGINE_TAG_EN
            chk($sformatf("%s U%0d out_tag", name, 1 << k), 256'(out_tag[k]), 256'(tag));
`endif
        end
        $display("chunk %-10s hash[U1]=%h latency U1/U2/U4/U8=%0d/%0d/%0d/%0d",
                 name, hash[0], first[0], first[1], first[2], first[3]);
    endtask

    typedef struct {
        string          name;
        logic [511:0]   blk;
        logic [255:0]   v;
        logic [31:0]    tag;
        logic [255:0]   digest;
    } vec_t;

    localparam logic [255:0] IV =
        256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;

    initial begin
        vec_t          tbl [2];
        logic [255:0]  snap [NI];
        logic [255:0]  v2;
        logic [511:0]  blk1, blk2;

        tbl[0].name   = "abc";
        tbl[0].blk    = {32'h61626380, {14{32'h0}}, 32'h00000018};
        tbl[0].v      = IV;
        tbl[0].tag    = 32'hdeadbeef;
        tbl[0].digest = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
        tbl[1].name   = "empty";
        tbl[1].blk    = {32'h80000000, {15{32'h0}}};
        tbl[1].v      = IV;
        tbl[1].tag    = 32'h00000001;
        tbl[1].digest = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data      = '0;
        v_in      = '0;
`ifdef SHA256_ROUND_ENGINE_TAG_EN
        in_tag    = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset U%0d in_ready", 1 << k), 256'(in_ready[k]), 256'(0));
            chk($sformatf("reset U%0d out_valid", 1 << k), 256'(out_valid[k]), 256'(0));
            chk($sformatf("reset U%0d busy", 1 << k), 256'(busy[k]), 256'(0));
            chk($sformatf("reset U%0d hash", 1 << k), hash[k], 256'(0));
`ifdef SHA256_ROUND_ENGINE_TAG_EN
            chk($sformatf("reset U%0d out_tag", 1 << k), 256'(out_tag[k]), 256'(0));
`endif
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++)
            chk($sformatf("idle U%0d in_ready", 1 << k), 256'(in_ready[k]), 256'(1));
        @(posedge clk);
        #1;

        for (int t = 0; t < 2; t++) begin
            run_chunk(tbl[t].name, pack_block(tbl[t].blk), tbl[t].v, tbl[t].tag,
                      pack_digest(tbl[t].digest), 1'b1);
            if (t == 0) begin
                // Backpressure: a waiting chunk must not disturb the held result.
                for (int k = 0; k < NI; k++) snap[k] = hash[k];
                in_valid = 1'b1;
                data     = pack_block(tbl[1].blk);
`ifdef SHA256_ROUND_ENGINE_TAG_EN
                in_tag   = 32'h00000001;
`endif
                for (int c = 1; c <= 20; c++) begin
                    @(posedge clk);
                    #1;
                    for (int k = 0; k < NI; k++) begin
                        chk($sformatf("hold c%0d U%0d out_valid", c, 1 << k), 256'(out_valid[k]), 256'(1));
                        chk($sformatf("hold c%0d U%0d hash", c, 1 << k), hash[k], snap[k]);
                        chk($sformatf("hold c%0d U%0d in_ready", c, 1 << k), 256'(in_ready[k]), 256'(0));
`ifdef SHA256_ROUND_ENGINE_TAG_EN
                        chk($sformatf("hold c%0d U%0d out_tag", c, 1 << k), 256'(out_tag[k]), 256'(32'hdeadbeef));
`endif
                    end
                end
                $display("hold       20 cycles of backpressure with in_valid=1 applied");
            end
        end

        // Reset in the middle of a UNROLL=1 run (edge 30 after accept).
        data      = pack_block(tbl[0].blk);
        v_in      = IV;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("midrun U1 busy before reset", 256'(busy[0]), 256'(1));
        rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("midrun reset U%0d hash", 1 << k), hash[k], 256'(0));
            chk($sformatf("midrun reset U%0d out_valid", 1 << k), 256'(out_valid[k]), 256'(0));
            chk($sformatf("midrun reset U%0d busy", 1 << k), 256'(busy[k]), 256'(0));
            chk($sformatf("midrun reset U%0d in_ready", 1 << k), 256'(in_ready[k]), 256'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("reset      asserted 30 edges into a run and released");
        run_chunk("abc-again", pack_block(tbl[0].blk), IV, 32'hcafef00d,
                  pack_digest(tbl[0].digest), 1'b1);

        // Two-block message: second block chains on the first block's result.
        blk1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk2 = {{15{32'h0}}, 32'h000001c0};
        run_chunk("2blk-1", pack_block(blk1), IV, 32'h00000010, '0, 1'b0);
        v2 = hash_to_v(hash[0]);
        run_chunk("2blk-2", pack_block(blk2), v2, 32'h00000020,
                  pack_digest(256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1),
                  1'b1);
        chk("2blk digest word0 unflipped", 256'(flip32(hash[0][31:0])), 256'(32'h248d6a61));

        // Final handshake drops out_valid and returns to IDLE.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("release U%0d out_valid", 1 << k), 256'(out_valid[k]), 256'(0));
            chk($sformatf("release U%0d in_ready", 1 << k), 256'(in_ready[k]), 256'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
